// File: rtl/emotion_arbiter.sv
// emotion_arbiter
//   Reduces the multi-hot emotional state vector to a single dominant emotion.
//   A fixed priority selects the candidate. A minimum dwell time and a
//   persistence check keep the displayed mood from flickering. All state
//   advances only on `tick` cycles. The sleep flag overrides everything else.
//
// Ports
//   clk              in   system clock
//   rst              in   asynchronous, active-high reset
//   tick             in   update strobe
//   emotional_state  in   [7:0] multi-hot flags (0 happy, 1 excited,
//                         2 stressed, 3 nervous, 4 bored, 5 angry, 6 calm,
//                         7 apathetic)
//   is_asleep        in   sleep flag
//   dominant         out  [7:0] one-hot committed emotion, 0 when none
//   dominant_idx     out  [2:0] bit index of dominant, 0 when not valid
//   valid            out  a committed emotion exists
//   changed          out  one-cycle pulse when dominant changes value
module emotion_arbiter #(
   parameter int HOLD_TICKS    = 8,
   parameter int CONFIRM_TICKS = 3,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [7:0] emotional_state,
   input  logic       is_asleep,
   output logic [7:0] dominant,
   output logic [2:0] dominant_idx,
   output logic       valid,
   output logic       changed
);

   typedef enum logic [1:0] {S_NONE, S_HOLD, S_CONFIRM, S_SLEEP} state_t;

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] CONF_C = CNT_W'(CONFIRM_TICKS);

   state_t           state_q;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] conf_q;
   logic [7:0]       cand_q;
   logic [7:0]       dom_q;
   logic [2:0]       idx_q;
   logic             valid_q;
   logic             changed_q;

   logic [7:0]       pick_d;
   logic [CNT_W-1:0] conf_inc_d;
   logic             commit_d;
   logic [7:0]       commit_val_d;

   // Priority order, highest first: 7, 5, 2, 3, 1, 0, 6, 4.
   function automatic logic [7:0] prio_pick(input logic [7:0] v);
      logic [7:0] r;
      r = 8'h00;
      if      (v[7]) r = 8'h80;
      else if (v[5]) r = 8'h20;
      else if (v[2]) r = 8'h04;
      else if (v[3]) r = 8'h08;
      else if (v[1]) r = 8'h02;
      else if (v[0]) r = 8'h01;
      else if (v[6]) r = 8'h40;
      else if (v[4]) r = 8'h10;
      return r;
   endfunction

   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign pick_d     = prio_pick(emotional_state);
   assign conf_inc_d = conf_q + 1'b1;

   // Every path that loads a new dominant value funnels through one commit
   // decision, so the sleep override only has to be checked in one place.
   always_comb begin
      commit_d     = 1'b0;
      commit_val_d = cand_q;
      if (tick && !is_asleep) begin
         case (state_q)
            S_NONE: begin
               if (pick_d != 8'h00) begin
                  commit_d     = 1'b1;
                  commit_val_d = pick_d;
               end
            end
            S_HOLD: begin
               if (dwell_q == '0 && pick_d != dom_q && CONF_C == CNT_W'(1)) begin
                  commit_d     = 1'b1;
                  commit_val_d = pick_d;
               end
            end
            S_CONFIRM: begin
               if (pick_d != dom_q && pick_d == cand_q && conf_inc_d >= CONF_C) begin
                  commit_d     = 1'b1;
                  commit_val_d = cand_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_NONE;
         dwell_q   <= '0;
         conf_q    <= '0;
         cand_q    <= 8'h00;
         dom_q     <= 8'h00;
         idx_q     <= 3'd0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         changed_q <= 1'b0;
         if (tick) begin
            if (is_asleep) begin
               // Pulse only when something was actually displayed.
               state_q   <= S_SLEEP;
               dom_q     <= 8'h00;
               idx_q     <= 3'd0;
               valid_q   <= 1'b0;
               changed_q <= valid_q;
               cand_q    <= 8'h00;
               conf_q    <= '0;
               dwell_q   <= '0;
            end else if (commit_d) begin
               changed_q <= 1'b1;
               cand_q    <= commit_val_d;
               conf_q    <= CONF_C;
               if (commit_val_d == 8'h00) begin
                  // Committing "no emotion" drops back to the idle state.
                  state_q <= S_NONE;
                  dom_q   <= 8'h00;
                  idx_q   <= 3'd0;
                  valid_q <= 1'b0;
                  dwell_q <= '0;
               end else begin
                  state_q <= S_HOLD;
                  dom_q   <= commit_val_d;
                  idx_q   <= onehot_idx(commit_val_d);
                  valid_q <= 1'b1;
                  dwell_q <= HOLD_C;
               end
            end else begin
               case (state_q)
                  S_SLEEP: state_q <= S_NONE;
                  S_HOLD: begin
                     if (dwell_q != '0) begin
                        dwell_q <= dwell_q - 1'b1;
                     end else if (pick_d != dom_q) begin
                        cand_q  <= pick_d;
                        conf_q  <= CNT_W'(1);
                        state_q <= S_CONFIRM;
                     end
                  end
                  S_CONFIRM: begin
                     // Dwell stays expired, so returning to HOLD re-evaluates next tick.
                     if (pick_d == dom_q) begin
                        state_q <= S_HOLD;
                     end else if (pick_d == cand_q) begin
                        conf_q <= conf_inc_d;
                     end else begin
                        cand_q <= pick_d;
                        conf_q <= CNT_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign dominant     = dom_q;
   assign dominant_idx = idx_q;
   assign valid        = valid_q;
   assign changed      = changed_q;

endmodule

// File: tb/tb_emotion_arbiter.sv
module tb_emotion_arbiter;

   localparam int HOLD    = 4;
   localparam int CONFIRM = 3;
   localparam int ORD [8] = '{7, 5, 2, 3, 1, 0, 6, 4};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] emotional_state = 8'h00;
   logic       is_asleep = 1'b0;
   logic [7:0] dominant;
   logic [2:0] dominant_idx;
   logic       valid;
   logic       changed;

   int n_tests = 0;
   int n_fail  = 0;

   emotion_arbiter #(
      .HOLD_TICKS(HOLD),
      .CONFIRM_TICKS(CONFIRM),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .emotional_state(emotional_state),
      .is_asleep(is_asleep),
      .dominant(dominant),
      .dominant_idx(dominant_idx),
      .valid(valid),
      .changed(changed)
   );

   always #5 clk = ~clk;

   // Behavioural model: committed emotion as an index (-1 = none), ticks
   // elapsed since the last commit, and the length of the current run of a
   // differing pick among evaluated ticks.
   int m_dom    = -1;
   bit m_sleep  = 1'b0;
   int m_since  = 0;
   int m_streak = 0;
   int m_sval   = -1;
   bit e_chg    = 1'b0;

   function automatic int pick(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[ORD[i]]) return ORD[i];
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_dom = -1; m_sleep = 1'b0; m_since = 0; m_streak = 0; m_sval = -1; e_chg = 1'b0;
   endtask

   task automatic model_step();
      int p;
      e_chg = 1'b0;
      if (!tick) return;
      p = pick(emotional_state);
      if (is_asleep) begin
         e_chg = (m_dom != -1);
         m_dom = -1; m_sleep = 1'b1; m_streak = 0;
      end else if (m_sleep) begin
         m_sleep = 1'b0;
      end else if (m_dom == -1) begin
         if (p != -1) begin
            m_dom = p; m_since = 0; m_streak = 0; e_chg = 1'b1;
         end
      end else begin
         m_since++;
         if (m_since > HOLD) begin
            if (p == m_dom) begin
               m_streak = 0;
            end else begin
               if (m_streak > 0 && p == m_sval) m_streak++;
               else begin m_sval = p; m_streak = 1; end
               if (m_streak >= CONFIRM) begin
                  m_dom = p; m_since = 0; m_streak = 0; e_chg = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic logic [12:0] model_out();
      logic [7:0] d;
      logic [2:0] ix;
      d  = (m_dom < 0) ? 8'h00 : (8'h01 << m_dom);
      ix = (m_dom < 0) ? 3'd0 : 3'(m_dom);
      return {d, ix, (m_dom >= 0), e_chg};
   endfunction

   // Per-cycle compare against the model, sampled 1 time unit after each edge.
   initial begin
      logic [12:0] got;
      logic [12:0] exp;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
         #1;
         got = {dominant, dominant_idx, valid, changed};
         exp = model_out();
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got dom=%h idx=%0d vld=%b chg=%b required dom=%h idx=%0d vld=%b chg=%b",
                     $time, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
         end
      end
   end

   task automatic chk(input string name, input logic [12:0] exp);
      logic [12:0] got;
      got = {dominant, dominant_idx, valid, changed};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got dom=%h idx=%0d vld=%b chg=%b required dom=%h idx=%0d vld=%b chg=%b",
                  name, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle at the falling edge; the next rising edge consumes it.
   task automatic step(input logic tk, input logic [7:0] es, input logic sl);
      @(negedge clk);
      tick = tk; emotional_state = es; is_asleep = sl;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n, input logic [7:0] es);
      for (int i = 0; i < n; i++) step(1'b1, es, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_state", {8'h00, 3'd0, 1'b0, 1'b0});
      rst = 1'b0;

      // First commit with priority: calm+happy -> happy.
      step(1'b1, 8'h41, 1'b0); settle();
      chk("first_commit", {8'h01, 3'd0, 1'b1, 1'b1});
      step(1'b0, 8'h41, 1'b0); settle();
      chk("changed_single", {8'h01, 3'd0, 1'b1, 1'b0});

      // Reset during activity, then idle.
      ticks(2, 8'h20);
      @(negedge clk); rst = 1'b1; tick = 1'b0; #1;
      chk("async_reset", {8'h00, 3'd0, 1'b0, 1'b0});
      @(negedge clk); rst = 1'b0;
      ticks(10, 8'h00); settle();
      chk("idle_after_reset", {8'h00, 3'd0, 1'b0, 1'b0});

      // Dwell/confirm timing: commit at tick 0, angry from tick 1.
      step(1'b1, 8'h01, 1'b0);
      ticks(6, 8'h20); settle();
      chk("no_early_switch", {8'h01, 3'd0, 1'b1, 1'b0});
      step(1'b1, 8'h20, 1'b0); settle();
      chk("switch_tick7", {8'h20, 3'd5, 1'b1, 1'b1});

      // Candidate jitter with current = angry.
      ticks(5, 8'h20);
      step(1'b1, 8'h04, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      ticks(2, 8'h04); settle();
      chk("jitter_hold", {8'h20, 3'd5, 1'b1, 1'b0});
      step(1'b1, 8'h04, 1'b0); settle();
      chk("jitter_commit", {8'h04, 3'd2, 1'b1, 1'b1});

      // Return to current during CONFIRM cancels.
      ticks(5, 8'h04);
      ticks(2, 8'h02);
      step(1'b1, 8'h04, 1'b0);
      ticks(2, 8'h02); settle();
      chk("cancel_held", {8'h04, 3'd2, 1'b1, 1'b0});
      step(1'b1, 8'h02, 1'b0); settle();
      chk("cancel_commit", {8'h02, 3'd1, 1'b1, 1'b1});

      // Sleep override mid-CONFIRM.
      ticks(5, 8'h02);
      step(1'b1, 8'h80, 1'b0);
      step(1'b1, 8'h80, 1'b1); settle();
      chk("sleep_clear", {8'h00, 3'd0, 1'b0, 1'b1});
      step(1'b1, 8'h80, 1'b1); settle();
      chk("sleep_again", {8'h00, 3'd0, 1'b0, 1'b0});
      step(1'b1, 8'h80, 1'b0); settle();
      chk("wake_no_commit", {8'h00, 3'd0, 1'b0, 1'b0});
      step(1'b1, 8'h80, 1'b0); settle();
      chk("wake_commit", {8'h80, 3'd7, 1'b1, 1'b1});

      // Drop to none with gated ticks in between.
      ticks(5, 8'h80);
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0); settle();
      chk("drop_pending", {8'h80, 3'd7, 1'b1, 1'b0});
      step(1'b1, 8'h00, 1'b0); settle();
      chk("drop_none", {8'h00, 3'd0, 1'b0, 1'b1});

      // Multi-hot from NONE: 0x5A -> nervous (bit 3).
      step(1'b1, 8'h5A, 1'b0); settle();
      chk("multihot_pick", {8'h08, 3'd3, 1'b1, 1'b1});
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0); settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
